mmreq_bus_sequencer: RTL and testbench
======================================

// Module: mmreq_bus_sequencer
// PURPOSE
// Sequences the 32-bit mmreq/mmresp Xillybus stream pair onto a single-master register bus.
// Pops command words from the host-write FIFO, performs one register read or write per command,
// and pushes read data (or a timeout marker) into the host-read FIFO. Sits between the
// Xillybus core's user_w_mmreq/user_r_mmresp ports and the design's register slaves.
// PARAMETERS
// ADDR_W        20            register address width; command word bits [ADDR_W-1:0]
// TIMEOUT_CYC   1024          cycles without reg_ack before a transaction is abandoned
// TIMEOUT_WORD  32'hDEADDEAD  response word returned on timeout
// PORTS
// bus_clk      in   1       single clock; all logic is synchronous to it
// bus_rst      in   1       synchronous, active-high reset
// req_data     in   32      head word of command FIFO (show-ahead; valid while !req_empty)
// req_empty    in   1       command FIFO empty
// req_open     in   1       host has the mmreq stream open
// req_rden     out  1       pop one command word
// resp_data    out  32      response word
// resp_full    in   1       response FIFO full
// resp_wren    out  1       push resp_data
// reg_addr     out  ADDR_W  register address, held for the whole transaction
// reg_wdata    out  32      write data, held for the whole transaction
// reg_wr       out  1       one-cycle write strobe
// reg_rd       out  1       one-cycle read strobe
// reg_rdata    in   32      read data, sampled when reg_ack=1
// reg_ack      in   1       slave completion, one cycle
// busy         out  1       high in any state other than IDLE
// timeout_cnt  out  16      saturating count of timed-out transactions
// BEHAVIOUR
// - Reset: state=IDLE; req_rden, resp_wren, reg_wr, reg_rd, busy = 0; reg_addr, reg_wdata,
//   resp_data, timeout_cnt = 0; timeout counter cleared. Reset mid-transaction drops it silently.
// - Command word: bit31 = WR (1 write, 0 read); bits[30:ADDR_W] ignored; bits[ADDR_W-1:0] = addr.
//   A write command is followed by exactly one data word.
// - IDLE: if !req_empty && req_open: latch addr/WR, req_rden=1 for one cycle;
//   WR=1 -> GET_DATA, WR=0 -> STROBE. Words arriving while req_open=0 are not popped.
// - GET_DATA: if !req_open -> IDLE (half command discarded, no bus access);
//   else if !req_empty: latch reg_wdata, req_rden=1 one cycle -> STROBE.
// - STROBE: reg_wr or reg_rd high exactly this cycle; wait counter cleared -> WAIT.
// - WAIT: reg_ack=1 -> latch resp_data=reg_rdata (reads) or 0 (writes) -> RESP_CHK.
//   reg_ack is ignored in the STROBE cycle (earliest accepted ack is 1 cycle after strobe).
//   Counter reaches TIMEOUT_CYC without ack -> resp_data=TIMEOUT_WORD, timeout_cnt+1
//   (saturates at 16'hFFFF) -> RESP_CHK. Late ack after timeout is ignored.
// - RESP_CHK: reads go to RESP; writes go to IDLE (see CONFIGURATION).
// - RESP: while resp_full=1 hold resp_data, resp_wren=0; when !resp_full: resp_wren=1 one cycle
//   -> IDLE. Response never dropped; req_open dropping here does not cancel the push.
// - Throughput: read = 1 pop + strobe + ack latency + 1 push; at most one outstanding transaction.
// - req_rden and resp_wren are never asserted in the same cycle; reg_wr/reg_rd never together.
// CONFIGURATION
// - MMREQ_WRITE_ACK_EN defined: writes also pass through RESP, pushing 32'h0 on ack or
//   TIMEOUT_WORD on timeout, so the host can count completions.
// - Not defined: writes return to IDLE after WAIT with no response word; a write timeout is
//   visible only through timeout_cnt.
// TESTING
// - Read: push 32'h0000_0040, reg_ack with rdata 32'h1234_5678 3 cycles after reg_rd -> reg_addr=0x40,
//   one reg_rd pulse, one resp_wren with 32'h1234_5678, busy low after.
// - Write: push 32'h8000_0010, 32'hCAFE_F00D -> one reg_wr pulse, reg_addr=0x10,
//   reg_wdata=32'hCAFE_F00D; no resp_wren (macro off) / resp 32'h0 (macro on).
// - Timeout: read 0x20 with slave never acking -> resp TIMEOUT_WORD after 1024 cycles in WAIT,
//   timeout_cnt=1; later stray reg_ack causes no extra push.
// - Backpressure: resp_full=1 for 50 cycles at RESP -> resp_data held, no push; push within 1 cycle
//   of resp_full falling; next command not popped until push done.
// - Abort: write command popped, req_open=0 before data word -> back to IDLE, no reg_wr,
//   remaining FIFO word not popped while closed.
// - Reset: bus_rst in WAIT -> next cycle all outputs at reset values, queued command handled fresh.

Source files
------------

// File: rtl/mmreq_bus_sequencer.sv
// mmreq_bus_sequencer: mmreq/mmresp stream pair to single-master register bus.
// Optional MMREQ_WRITE_ACK_EN: writes also push a completion word.
module mmreq_bus_sequencer #(
  parameter int          ADDR_W       = 20,
  parameter int          TIMEOUT_CYC  = 1024,
  parameter logic [31:0] TIMEOUT_WORD = 32'hDEADDEAD
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  input  logic [31:0]       req_data,
  input  logic              req_empty,
  input  logic              req_open,
  output logic              req_rden,
  output logic [31:0]       resp_data,
  input  logic              resp_full,
  output logic              resp_wren,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [31:0]       reg_rdata,
  input  logic              reg_ack,
  output logic              busy,
  output logic [15:0]       timeout_cnt
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_DATA,
    S_STROBE,
    S_WAIT,
    S_RESP_CHK,
    S_RESP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          is_wr;
  logic [CW-1:0] wait_cnt;
  logic          to_hit;
  logic          unused_bits;

  // Command bits between WR and the address field carry no meaning.
  assign unused_bits = ^req_data[30:ADDR_W];

  assign busy   = (state_q != S_IDLE);
  assign to_hit = (wait_cnt == TO_LAST);

  // State register.
  always_ff @(posedge bus_clk) begin
    if (bus_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and one-cycle strobes; all strobes forced low in reset.
  always_comb begin
    state_d   = state_q;
    req_rden  = 1'b0;
    resp_wren = 1'b0;
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!req_empty && req_open) begin
          req_rden = 1'b1;
          state_d  = req_data[31] ? S_GET_DATA : S_STROBE;
        end
      end
      S_GET_DATA: begin
        if (!req_open) begin
          state_d = S_IDLE;
        end else if (!req_empty) begin
          req_rden = 1'b1;
          state_d  = S_STROBE;
        end
      end
      S_STROBE: begin
        reg_wr  = is_wr;
        reg_rd  = !is_wr;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (reg_ack || to_hit) state_d = S_RESP_CHK;
      end
      S_RESP_CHK: begin
`ifdef MMREQ_WRITE_ACK_EN
        state_d = S_RESP;
`else
        state_d = is_wr ? S_IDLE : S_RESP;
`endif
      end
      S_RESP: begin
        if (!resp_full) begin
          resp_wren = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus_rst) begin
      req_rden  = 1'b0;
      resp_wren = 1'b0;
      reg_wr    = 1'b0;
      reg_rd    = 1'b0;
    end
  end

  // Command/data latches, wait counter, response word and timeout tally.
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      is_wr       <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      resp_data   <= '0;
      timeout_cnt <= '0;
      wait_cnt    <= '0;
    end else begin
      if (state_q == S_IDLE && req_rden) begin
        reg_addr <= req_data[ADDR_W-1:0];
        is_wr    <= req_data[31];
      end
      if (state_q == S_GET_DATA && req_rden)
        reg_wdata <= req_data;
      if (state_q == S_STROBE)
        wait_cnt <= '0;
      if (state_q == S_WAIT) begin
        if (reg_ack) begin
          resp_data <= is_wr ? 32'h0 : reg_rdata;
        end else if (to_hit) begin
          resp_data <= TIMEOUT_WORD;
          if (timeout_cnt != 16'hFFFF)
            timeout_cnt <= timeout_cnt + 16'd1;
        end else begin
          wait_cnt <= wait_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mmreq_bus_sequencer.sv
// tb_mmreq_bus_sequencer: directed scenarios for mmreq_bus_sequencer.
// FIFO, slave and response sink are modelled inline.
module tb_mmreq_bus_sequencer;

  logic        bus_clk = 1'b0;
  logic        bus_rst;
  logic [31:0] req_data;
  logic        req_empty;
  logic        req_open;
  logic        req_rden;
  logic [31:0] resp_data;
  logic        resp_full;
  logic        resp_wren;
  logic [19:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic        busy;
  logic [15:0] timeout_cnt;

  mmreq_bus_sequencer dut (
    .bus_clk(bus_clk), .bus_rst(bus_rst),
    .req_data(req_data), .req_empty(req_empty),
    .req_open(req_open), .req_rden(req_rden),
    .resp_data(resp_data), .resp_full(resp_full),
    .resp_wren(resp_wren), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack), .busy(busy),
    .timeout_cnt(timeout_cnt)
  );

  always #5 bus_clk = ~bus_clk;

  int errs = 0;
  int checks = 0;

  logic [31:0] q[$];
  int          cyc = 0;
  int          ack_delay = 0;
  int          ack_at = 0;
  logic        armed = 1'b0;
  logic        ack_model = 1'b0;
  logic        stray = 1'b0;
  logic        do_pop = 1'b0;
  int          pop_cnt = 0, rd_cnt = 0, wr_cnt = 0, resp_cnt = 0;
  int          strobe_cyc = 0, push_cyc = 0;
  logic [19:0] st_addr = '0;
  logic [31:0] st_wdata = '0;
  logic [31:0] last_resp = '0;

  assign reg_ack = ack_model | stray;

  always @(posedge bus_clk) begin
    if (!bus_rst) begin
      if (req_rden) begin
        pop_cnt++;
        do_pop = 1'b1;
      end
      if (reg_rd || reg_wr) begin
        if (reg_rd) rd_cnt++;
        if (reg_wr) wr_cnt++;
        strobe_cyc = cyc;
        st_addr = reg_addr;
        st_wdata = reg_wdata;
        if (ack_delay != 0) begin
          armed = 1'b1;
          ack_at = cyc + ack_delay;
        end
      end
      if (resp_wren) begin
        resp_cnt++;
        last_resp = resp_data;
        push_cyc = cyc;
      end
    end
    cyc++;
    #1;
    if (do_pop && q.size() > 0) void'(q.pop_front());
    do_pop = 1'b0;
    req_empty = (q.size() == 0);
    req_data = (q.size() == 0) ? 32'h0 : q[0];
    ack_model = armed && (cyc == ack_at);
    if (ack_model) armed = 1'b0;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge bus_clk);
  endtask

  task automatic test_reset;
    bus_rst = 1'b1;
    step(3);
    checks++;
    if (busy !== 1'b0 || req_rden !== 1'b0 || resp_wren !== 1'b0 ||
        reg_wr !== 1'b0 || reg_rd !== 1'b0) begin
      errs++;
      $display("FAIL reset_ctl busy=%b rden=%b wren=%b wr=%b rd=%b want 0",
               busy, req_rden, resp_wren, reg_wr, reg_rd);
    end
    checks++;
    if (reg_addr !== 20'h0 || reg_wdata !== 32'h0 ||
        resp_data !== 32'h0 || timeout_cnt !== 16'h0) begin
      errs++;
      $display("FAIL reset_data addr=%h wd=%h rsp=%h to=%h want 0",
               reg_addr, reg_wdata, resp_data, timeout_cnt);
    end
    bus_rst = 1'b0;
    step(2);
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_read;
    int r0, d0;
    r0 = resp_cnt;
    d0 = rd_cnt;
    reg_rdata = 32'h1234_5678;
    ack_delay = 3;
    q.push_back(32'h0000_0040);
    for (int i = 0; i < 40 && resp_cnt == r0; i++) step(1);
    step(1);
    checks++;
    if (resp_cnt !== r0 + 1 || last_resp !== 32'h1234_5678) begin
      errs++;
      $display("FAIL read_resp got n=%0d d=%h want n=%0d d=12345678",
               resp_cnt - r0, last_resp, 1);
    end
    checks++;
    if (rd_cnt !== d0 + 1 || st_addr !== 20'h40 || reg_addr !== 20'h40) begin
      errs++;
      $display("FAIL read_strobe got rd=%0d addr=%h want rd=1 addr=40",
               rd_cnt - d0, st_addr);
    end
    checks++;
    if (push_cyc - strobe_cyc !== 5) begin
      errs++;
      $display("FAIL read_latency got %0d want 5", push_cyc - strobe_cyc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL read_busy got %b want 0", busy);
    end
  endtask

  task automatic test_write;
    int r0, w0, d0;
    r0 = resp_cnt;
    w0 = wr_cnt;
    d0 = rd_cnt;
    ack_delay = 2;
    reg_rdata = 32'h7777_7777;
    q.push_back(32'h8000_0010);
    q.push_back(32'hCAFE_F00D);
    for (int i = 0; i < 40 && wr_cnt == w0; i++) step(1);
    step(8);
    checks++;
    if (wr_cnt !== w0 + 1 || rd_cnt !== d0 || st_addr !== 20'h10 ||
        st_wdata !== 32'hCAFE_F00D) begin
      errs++;
      $display("FAIL write_strobe got wr=%0d rd=%0d a=%h d=%h want 1 0 10 cafef00d",
               wr_cnt - w0, rd_cnt - d0, st_addr, st_wdata);
    end
`ifdef MMREQ_WRITE_ACK_EN
    checks++;
    if (resp_cnt !== r0 + 1 || last_resp !== 32'h0) begin
      errs++;
      $display("FAIL write_resp got n=%0d d=%h want 1 0",
               resp_cnt - r0, last_resp);
    end
`else
    checks++;
    if (resp_cnt !== r0) begin
      errs++;
      $display("FAIL write_noresp got n=%0d want 0", resp_cnt - r0);
    end
`endif
    checks++;
    if (busy !== 1'b0 || q.size() != 0) begin
      errs++;
      $display("FAIL write_done busy=%b q=%0d want 0 0", busy, q.size());
    end
  endtask

  task automatic test_timeout;
    int r0;
    r0 = resp_cnt;
    ack_delay = 0;
    q.push_back(32'h0000_0020);
    for (int i = 0; i < 1200 && resp_cnt == r0; i++) step(1);
    step(1);
    checks++;
    if (resp_cnt !== r0 + 1 || last_resp !== 32'hDEAD_DEAD) begin
      errs++;
      $display("FAIL timeout_resp got n=%0d d=%h want 1 deaddead",
               resp_cnt - r0, last_resp);
    end
    checks++;
    if (push_cyc - strobe_cyc !== 1026) begin
      errs++;
      $display("FAIL timeout_len got %0d want 1026", push_cyc - strobe_cyc);
    end
    checks++;
    if (timeout_cnt !== 16'd1) begin
      errs++;
      $display("FAIL timeout_cnt got %0d want 1", timeout_cnt);
    end
    stray = 1'b1;
    step(1);
    stray = 1'b0;
    step(5);
    checks++;
    if (resp_cnt !== r0 + 1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL timeout_stray got n=%0d busy=%b want 1 0",
               resp_cnt - r0, busy);
    end
  endtask

  task automatic test_backpressure;
    int r0, p0, d0;
    r0 = resp_cnt;
    p0 = pop_cnt;
    d0 = rd_cnt;
    resp_full = 1'b1;
    ack_delay = 1;
    reg_rdata = 32'hA5A5_0001;
    q.push_back(32'h0000_0060);
    q.push_back(32'h0000_0064);
    for (int i = 0; i < 40 && rd_cnt == d0; i++) step(1);
    step(50);
    checks++;
    if (resp_cnt !== r0 || resp_data !== 32'hA5A5_0001 || busy !== 1'b1) begin
      errs++;
      $display("FAIL bp_hold got n=%0d d=%h busy=%b want 0 a5a50001 1",
               resp_cnt - r0, resp_data, busy);
    end
    checks++;
    if (pop_cnt !== p0 + 1) begin
      errs++;
      $display("FAIL bp_nopop got pops=%0d want 1", pop_cnt - p0);
    end
    reg_rdata = 32'hA5A5_0002;
    resp_full = 1'b0;
    #1;
    checks++;
    if (resp_wren !== 1'b1) begin
      errs++;
      $display("FAIL bp_release got wren=%b want 1", resp_wren);
    end
    for (int i = 0; i < 40 && resp_cnt < r0 + 2; i++) step(1);
    step(1);
    checks++;
    if (resp_cnt !== r0 + 2 || last_resp !== 32'hA5A5_0002 ||
        st_addr !== 20'h64 || pop_cnt !== p0 + 2) begin
      errs++;
      $display("FAIL bp_next got n=%0d d=%h a=%h pops=%0d want 2 a5a50002 64 2",
               resp_cnt - r0, last_resp, st_addr, pop_cnt - p0);
    end
  endtask

  task automatic test_abort;
    int p0, w0;
    p0 = pop_cnt;
    w0 = wr_cnt;
    ack_delay = 1;
    q.push_back(32'h8000_0010);
    for (int i = 0; i < 20 && pop_cnt == p0; i++) step(1);
    req_open = 1'b0;
    q.push_back(32'hCAFE_F00D);
    step(10);
    checks++;
    if (wr_cnt !== w0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_nowr got wr=%0d busy=%b want 0 0", wr_cnt - w0, busy);
    end
    checks++;
    if (pop_cnt !== p0 + 1 || q.size() != 1) begin
      errs++;
      $display("FAIL abort_nopop got pops=%0d q=%0d want 1 1",
               pop_cnt - p0, q.size());
    end
    q.delete();
    step(2);
    req_open = 1'b1;
    step(2);
  endtask

  task automatic test_reset_mid;
    int r0, d0;
    d0 = rd_cnt;
    ack_delay = 0;
    q.push_back(32'h0000_0030);
    for (int i = 0; i < 20 && rd_cnt == d0; i++) step(1);
    step(3);
    checks++;
    if (busy !== 1'b1 || reg_addr !== 20'h30) begin
      errs++;
      $display("FAIL mid_wait busy=%b addr=%h want 1 30", busy, reg_addr);
    end
    bus_rst = 1'b1;
    armed = 1'b0;
    q.push_back(32'h0000_0050);
    step(2);
    checks++;
    if (busy !== 1'b0 || reg_addr !== 20'h0 || resp_data !== 32'h0 ||
        timeout_cnt !== 16'h0 || req_rden !== 1'b0 || reg_rd !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset busy=%b a=%h rsp=%h to=%0d rden=%b rd=%b want 0",
               busy, reg_addr, resp_data, timeout_cnt, req_rden, reg_rd);
    end
    r0 = resp_cnt;
    ack_delay = 2;
    reg_rdata = 32'h5A5A_1234;
    bus_rst = 1'b0;
    for (int i = 0; i < 40 && resp_cnt == r0; i++) step(1);
    step(1);
    checks++;
    if (resp_cnt !== r0 + 1 || last_resp !== 32'h5A5A_1234 ||
        st_addr !== 20'h50) begin
      errs++;
      $display("FAIL mid_fresh got n=%0d d=%h a=%h want 1 5a5a1234 50",
               resp_cnt - r0, last_resp, st_addr);
    end
  endtask

  initial begin
    bus_rst = 1'b1;
    req_open = 1'b1;
    resp_full = 1'b0;
    reg_rdata = 32'h0;
    req_empty = 1'b1;
    req_data = 32'h0;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
